// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: one word-aligned memory read per instruction, valid/ready to decode
module ifu_fetch #(
    parameter int XLEN  = 64,
    parameter int BUS_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            fetch_en,
    input  logic            redirect,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [BUS_W-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err,
    output logic [XLEN-1:0] fetch_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        DROP  = 3'd4
    } state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc_q;
    logic            latch_pc;
    logic            mis_load;
    logic            rsp_load;
    logic            cnt_inc;
    logic            pc_misaligned;

    assign pc_misaligned = (pc[1:0] != 2'b00);
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = {pc_q[XLEN-1:3], 3'b000};
    assign inst_valid    = (state == VALID);

    always_comb begin
        state_d  = state;
        latch_pc = 1'b0;
        mis_load = 1'b0;
        rsp_load = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_en && !redirect) begin
                    latch_pc = 1'b1;
                    mis_load = pc_misaligned;
                    state_d  = pc_misaligned ? VALID : REQ;
                end
            end
            REQ: begin
                // an accepted request still owes us a beat, so a flush must drain it
                if (redirect)
                    state_d = mem_req_ready ? DROP : IDLE;
                else if (mem_req_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_load = !redirect;
                    state_d  = redirect ? IDLE : VALID;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            VALID: begin
                if (redirect) begin
                    state_d = IDLE;
                end else if (inst_ready) begin
                    cnt_inc = 1'b1;
                    if (fetch_en) begin
                        latch_pc = 1'b1;
                        mis_load = pc_misaligned;
                        state_d  = pc_misaligned ? VALID : REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (mem_rsp_valid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc_q      <= '0;
            inst      <= '0;
            inst_pc   <= '0;
            inst_err  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state <= state_d;
            if (latch_pc)
                pc_q <= pc;
            if (mis_load) begin
                inst     <= '0;
                inst_pc  <= pc;
                inst_err <= 1'b1;
            end
            if (rsp_load) begin
                inst     <= mem_rsp_err ? 32'd0
                          : (pc_q[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0]);
                inst_pc  <= pc_q;
                inst_err <= mem_rsp_err;
            end
            if (cnt_inc)
                fetch_cnt <= fetch_cnt + XLEN'(1);
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scoreboard bench for ifu_fetch with a stallable memory responder
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc;
    logic        fetch_en;
    logic        redirect;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_err;
    logic [63:0] fetch_cnt;

    ifu_fetch #(.XLEN(64), .BUS_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .fetch_en      (fetch_en),
        .redirect      (redirect),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_err      (inst_err),
        .fetch_cnt     (fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   handovers = 0;

    int          stall_left = 0;
    int          rsp_delay  = 0;
    logic        rsp_err_flag = 1'b0;
    logic        pend = 1'b0;
    int          pend_wait = 0;
    logic [63:0] pend_addr = '0;
    logic        pend_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000)
            return 64'h0000_0013_0010_0093;
        return {a[31:0] ^ 32'h1234_5678, a[31:0] ^ 32'h0BAD_F00D};
    endfunction

    function automatic exp_t exp_of(input logic [63:0] a, input logic err);
        exp_t e;
        logic [63:0] d;
        e.pc = a;
        if (a[1:0] != 2'b00) begin
            e.inst = 32'd0;
            e.err  = 1'b1;
        end else begin
            d      = mem_word({a[63:3], 3'b000});
            e.inst = err ? 32'd0 : (a[2] ? d[63:32] : d[31:0]);
            e.err  = err;
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory model: ready after stall_left refusals, one beat rsp_delay cycles after acceptance.
    always begin
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        if (pend) begin
            if (pend_wait == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_word(pend_addr);
                mem_rsp_err   = pend_err;
                pend          = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                mem_req_ready = 1'b1;
                pend      = 1'b1;
                pend_wait = rsp_delay;
                pend_addr = mem_req_addr;
                pend_err  = rsp_err_flag;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_inst", {32'd0, inst}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("sb_inst", {32'd0, inst}, {32'd0, e.inst});
                check("sb_inst_pc", inst_pc, e.pc);
                check("sb_inst_err", {63'd0, inst_err}, {63'd0, e.err});
            end
            handovers++;
        end
    end

    task automatic do_fetch(input logic [63:0] a, input logic push);
        pc       = a;
        fetch_en = 1'b1;
        if (push)
            exp_q.push_back(exp_of(a, (a[1:0] == 2'b00) && rsp_err_flag));
        tick;
        fetch_en = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n = 1;
        while (!inst_valid && n < 30) begin
            tick;
            n++;
        end
        check(tag, 64'(n), 64'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pc = '0; fetch_en = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
        repeat (3) tick;
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_req_addr", mem_req_addr, 64'd0);
        check("rst_inst", {32'd0, inst}, 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
        check("rst_fetch_cnt", fetch_cnt, 64'd0);
        rst = 1'b0;
        inst_ready = 1'b1;
        tick;

        // 1: aligned low word, minimum latency
        do_fetch(64'h8000_0000, 1'b1);
        check("t1_req_valid", {63'd0, mem_req_valid}, 64'd1);
        check("t1_req_addr", mem_req_addr, 64'h8000_0000);
        wait_valid("t1_latency", 3);
        tick;
        check("t1_fetch_cnt", fetch_cnt, 64'd1);

        // 2: upper word of the same beat
        do_fetch(64'h8000_0004, 1'b1);
        check("t2_req_addr", mem_req_addr, 64'h8000_0000);
        wait_valid("t2_latency", 3);
        tick;

        // 3: misaligned pc, no bus access
        do_fetch(64'h8000_0002, 1'b1);
        check("t3_no_req", {63'd0, mem_req_valid}, 64'd0);
        wait_valid("t3_latency", 1);
        tick;

        // 4: request stalled for five cycles
        stall_left = 5;
        do_fetch(64'h8000_0014, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_req_valid_%0d", i), {63'd0, mem_req_valid}, 64'd1);
            check($sformatf("t4_req_addr_%0d", i), mem_req_addr, 64'h8000_0010);
            tick;
        end
        wait_valid("t4_latency", 3);
        tick;

        // bus fault response
        rsp_err_flag = 1'b1;
        do_fetch(64'h8000_0018, 1'b1);
        wait_valid("err_latency", 3);
        tick;
        rsp_err_flag = 1'b0;

        // 5: redirect in WAIT before the response arrives
        rsp_delay = 3;
        do_fetch(64'h8000_0010, 1'b0);
        tick;
        redirect = 1'b1;
        tick;
        redirect = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t5_no_inst_%0d", i), {63'd0, inst_valid}, 64'd0);
            check($sformatf("t5_no_req_%0d", i), {63'd0, mem_req_valid}, 64'd0);
            tick;
        end
        rsp_delay = 0;
        do_fetch(64'h8000_0008, 1'b1);
        wait_valid("t5_latency", 3);
        tick;
        check("t5_fetch_cnt", fetch_cnt, 64'd6);

        // 6: downstream backpressure, back-to-back accept, then reset mid-WAIT
        inst_ready = 1'b0;
        do_fetch(64'h8000_0020, 1'b1);
        wait_valid("t6_latency", 3);
        rsp_delay = 3;
        pc = 64'h8000_000C;
        fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check($sformatf("t6_hold_valid_%0d", i), {63'd0, inst_valid}, 64'd1);
            check($sformatf("t6_hold_inst_%0d", i), {32'd0, inst}, {32'd0, exp_of(64'h8000_0020, 1'b0).inst});
            check($sformatf("t6_hold_pc_%0d", i), inst_pc, 64'h8000_0020);
            check($sformatf("t6_hold_noreq_%0d", i), {63'd0, mem_req_valid}, 64'd0);
        end
        inst_ready = 1'b1;
        exp_q.push_back(exp_of(64'h8000_000C, 1'b0));
        tick;
        fetch_en = 1'b0;
        inst_ready = 1'b0;
        check("t6_req_valid", {63'd0, mem_req_valid}, 64'd1);
        check("t6_req_addr", mem_req_addr, 64'h8000_0008);
        check("t6_fetch_cnt", fetch_cnt, 64'd7);
        tick;
        rst = 1'b1;
        tick;
        check("t6_rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("t6_rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("t6_rst_req_addr", mem_req_addr, 64'd0);
        check("t6_rst_inst", {32'd0, inst}, 64'd0);
        check("t6_rst_inst_pc", inst_pc, 64'd0);
        check("t6_rst_inst_err", {63'd0, inst_err}, 64'd0);
        check("t6_rst_fetch_cnt", fetch_cnt, 64'd0);
        rst = 1'b0;
        exp_q.delete();
        handovers = 0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t6_idle_%0d", i), {63'd0, inst_valid}, 64'd0);
            tick;
        end

        rsp_delay = 0;
        inst_ready = 1'b1;
        do_fetch(64'h8000_0004, 1'b1);
        wait_valid("recover_latency", 3);
        tick;
        check("end_fetch_cnt", fetch_cnt, 64'(handovers));
        check("end_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
